// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that shares one pipelined CORDIC between NUM_REQ requesters.
// Results return in issue order and are steered back through an ID FIFO. Mode changes drain the pipe first.
module cordic_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 56,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                               i_clk,
  input  logic                               i_sync_rst_n,
  input  logic                               i_en,
  input  logic [NUM_REQ-1:0]                 i_req_vld,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0][1:0]            i_req_mode,
  output logic [NUM_REQ-1:0]                 o_req_rdy,
  output logic                               o_cordic_vld,
  output logic [DATA_WIDTH-1:0]              o_cordic_data,
  output logic [1:0]                         o_cordic_mode,
  input  logic                               i_cordic_vld,
  input  logic [DATA_WIDTH-1:0]              i_cordic_data,
  output logic [NUM_REQ-1:0]                 o_rsp_vld,
  output logic [DATA_WIDTH-1:0]              o_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
  output logic                               o_busy,
  output logic                               o_err_orphan
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ISSUE, DRAIN, SWITCH} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic                lock_vld;
  logic [ID_WIDTH-1:0] lock_id;
  logic [ID_WIDTH-1:0] fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  logic                cand_found;
  logic [ID_WIDTH-1:0] cand;
  logic                mode_ok, full, grant, accept, pop;

  function automatic logic [ID_WIDTH-1:0] rr_idx(input logic [ID_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  // A held lock overrides the rotating search so the switched-to requester goes first.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    if (lock_vld) begin
      cand       = lock_id;
      cand_found = i_req_vld[lock_id];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!cand_found && i_req_vld[rr_idx(rr_ptr, i)]) begin
          cand_found = 1'b1;
          cand       = rr_idx(rr_ptr, i);
        end
      end
    end
  end

  assign mode_ok = (i_req_mode[cand] == o_cordic_mode);
  assign full    = (o_outstanding == CNT_W'(MAX_OUTSTANDING));
  assign grant   = i_sync_rst_n && (state == ISSUE) && i_en && cand_found && mode_ok && !full;

  always_comb begin
    o_req_rdy = '0;
    if (grant) o_req_rdy[cand] = 1'b1;
  end

  assign accept = |(i_req_vld & o_req_rdy);
  assign pop    = i_cordic_vld && (o_outstanding != '0);
  assign o_busy = (o_outstanding != '0) || (state != ISSUE);

  always_ff @(posedge i_clk) begin
    if (accept) fifo[wr_ptr] <= cand;
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state         <= ISSUE;
      rr_ptr        <= '0;
      lock_vld      <= 1'b0;
      lock_id       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_outstanding <= '0;
      o_cordic_vld  <= 1'b0;
      o_cordic_data <= '0;
      o_cordic_mode <= 2'b00;
      o_rsp_vld     <= '0;
      o_rsp_data    <= '0;
      o_err_orphan  <= 1'b0;
    end else begin
      o_cordic_vld  <= accept;
      if (accept) begin
        o_cordic_data <= i_req_data[cand];
        wr_ptr        <= wr_ptr + 1'b1;
      end
      o_outstanding <= o_outstanding + CNT_W'(accept) - CNT_W'(pop);

      o_rsp_vld <= '0;
      if (pop) begin
        rd_ptr              <= rd_ptr + 1'b1;
        o_rsp_vld[fifo[rd_ptr]] <= 1'b1;
        o_rsp_data          <= i_cordic_data;
      end
      // A result with no tag behind it cannot be routed; flag it and drop it.
      if (i_cordic_vld && (o_outstanding == '0)) o_err_orphan <= 1'b1;

      case (state)
        ISSUE: begin
          if (accept) begin
            rr_ptr   <= rr_idx(cand, 1);
            lock_vld <= 1'b0;
          end else if (lock_vld && !i_req_vld[lock_id]) begin
            lock_vld <= 1'b0;
          end else if (i_en && cand_found && !mode_ok) begin
            lock_vld <= 1'b1;
            lock_id  <= cand;
            state    <= (o_outstanding == '0) ? SWITCH : DRAIN;
          end
        end
        DRAIN: begin
          if ((o_outstanding == '0) && !o_cordic_vld) state <= SWITCH;
        end
        SWITCH: begin
          o_cordic_mode <= i_req_mode[lock_id];
          state         <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a stub CORDIC (5-cycle delay, data+1) and an in-order response scoreboard.
module tb_cordic_arbiter;
  localparam int NR = 4;
  localparam int DW = 56;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, en;
  logic [NR-1:0]          req_vld, req_rdy;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0][1:0]     req_mode;
  logic                   c_vld, cv;
  logic [DW-1:0]          c_data, cd;
  logic [1:0]             c_mode;
  logic [NR-1:0]          rsp_vld;
  logic [DW-1:0]          rsp_data;
  logic [4:0]             outstanding;
  logic                   busy, orphan;

  cordic_arbiter dut (
    .i_clk(clk), .i_sync_rst_n(rst_n), .i_en(en),
    .i_req_vld(req_vld), .i_req_data(req_data), .i_req_mode(req_mode), .o_req_rdy(req_rdy),
    .o_cordic_vld(c_vld), .o_cordic_data(c_data), .o_cordic_mode(c_mode),
    .i_cordic_vld(cv), .i_cordic_data(cd),
    .o_rsp_vld(rsp_vld), .o_rsp_data(rsp_data), .o_outstanding(outstanding),
    .o_busy(busy), .o_err_orphan(orphan)
  );

  typedef struct {int id; logic [DW-1:0] data;} tr_t;
  typedef struct {logic [DW-1:0] data; int due;} st_t;

  tr_t exp_q[$];
  tr_t rsp_q[$];
  int  acc_q[$];
  st_t sq[$];
  int  cyc, n_vec, n_err;
  bit  stall, rel1, inj;
  logic [DW-1:0] inj_d;

  // One clock: sample handshakes/outputs at negedge, then drive the stub return after the edge.
  task automatic step();
    tr_t t;
    st_t s;
    logic [NR-1:0] took;
    @(negedge clk);
    took = '0;
    for (int k = 0; k < NR; k++) begin
      if (req_vld[k] && req_rdy[k]) begin
        acc_q.push_back(k);
        t.id = k; t.data = req_data[k] + DW'(1);
        exp_q.push_back(t);
        took[k] = 1'b1;
      end
    end
    if (c_vld === 1'b1) begin
      s.data = c_data + DW'(1); s.due = cyc + 5;
      sq.push_back(s);
    end
    if (rsp_vld !== '0 && !$isunknown(rsp_vld)) begin
      t.id = -1;
      for (int k = 0; k < NR; k++) if (rsp_vld[k]) t.id = (t.id == -1) ? k : -2;
      t.data = rsp_data;
      rsp_q.push_back(t);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) if (took[k]) req_data[k] = DW'({$urandom, $urandom});
    cv = 1'b0;
    if (inj) begin
      cv = 1'b1; cd = inj_d; inj = 1'b0;
    end else if (sq.size() > 0 && sq[0].due <= cyc && (!stall || rel1)) begin
      s = sq.pop_front();
      cv = 1'b1; cd = s.data; rel1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req_vld = '0; req_mode = '0;
    for (int k = 0; k < NR; k++) req_data[k] = DW'({$urandom, $urandom});
    cv = 1'b0; cd = '0; stall = 0; rel1 = 0; inj = 0; inj_d = '0;
    step(); step();
    n_vec++;
    if ({req_rdy, c_vld, rsp_vld} !== '0) begin
      n_err++; $display("FAIL reset_handshake got rdy=%b cvld=%b rsp=%b want 0", req_rdy, c_vld, rsp_vld);
    end
    n_vec++;
    if ({c_data, c_mode, rsp_data} !== '0) begin
      n_err++; $display("FAIL reset_data got cdata=%h mode=%b rsp=%h want 0", c_data, c_mode, rsp_data);
    end
    n_vec++;
    if ({outstanding, busy, orphan} !== '0) begin
      n_err++; $display("FAIL reset_status got cnt=%0d busy=%b orphan=%b want 0", outstanding, busy, orphan);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fairness();
    tr_t r, e;
    req_mode = '0; req_vld = '1;
    repeat (24) step();
    req_vld = '0;
    repeat (20) step();
    n_vec++;
    if (acc_q.size() != 24) begin
      n_err++; $display("FAIL fair_count got %0d accepts want 24", acc_q.size());
    end
    for (int i = 0; i < acc_q.size(); i++) begin
      n_vec++;
      if (acc_q[i] !== i % NR) begin
        n_err++; $display("FAIL fair_order[%0d] got %0d want %0d", i, acc_q[i], i % NR);
      end
    end
    acc_q.delete();
    while (rsp_q.size() > 0) begin
      r = rsp_q.pop_front(); n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL fair_rsp extra id=%0d", r.id); end
      else begin
        e = exp_q.pop_front();
        if (r.id !== e.id || r.data !== e.data) begin
          n_err++; $display("FAIL fair_rsp got id=%0d data=%h want id=%0d data=%h", r.id, r.data, e.id, e.data);
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL fair_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_full();
    tr_t r, e;
    stall = 1; req_mode = '0; req_vld = 4'b0001;
    repeat (24) step();
    n_vec++;
    if (acc_q.size() != 16) begin n_err++; $display("FAIL full_accepts got %0d want 16", acc_q.size()); end
    n_vec++;
    if (outstanding !== 5'd16) begin n_err++; $display("FAIL full_count got %0d want 16", outstanding); end
    n_vec++;
    if (req_rdy !== '0) begin n_err++; $display("FAIL full_rdy got %b want 0", req_rdy); end
    rel1 = 1;
    repeat (8) step();
    n_vec++;
    if (acc_q.size() != 17) begin n_err++; $display("FAIL full_one_more got %0d want 17", acc_q.size()); end
    n_vec++;
    if (outstanding !== 5'd16) begin n_err++; $display("FAIL full_refill got %0d want 16", outstanding); end
    stall = 0; req_vld = '0;
    repeat (30) step();
    acc_q.delete();
    while (rsp_q.size() > 0) begin
      r = rsp_q.pop_front(); n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL full_rsp extra id=%0d", r.id); end
      else begin
        e = exp_q.pop_front();
        if (r.id !== e.id || r.data !== e.data) begin
          n_err++; $display("FAIL full_rsp got id=%0d data=%h want id=%0d data=%h", r.id, r.data, e.id, e.data);
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL full_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_mode_switch();
    tr_t r, e;
    int zero_t, mode_t, grant_t, rsp_at_grant;
    stall = 1; req_mode = '0; req_vld = 4'b0001;
    for (int t = 0; t < 20 && acc_q.size() < 3; t++) step();
    req_vld = '0;
    n_vec++;
    if (acc_q.size() != 3) begin n_err++; $display("FAIL ms_setup got %0d accepts want 3", acc_q.size()); end
    acc_q.delete();
    req_mode[1] = 2'd2; req_vld = 4'b0010;
    repeat (6) step();
    n_vec++;
    if (acc_q.size() != 0 || c_mode !== 2'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL ms_hold got acc=%0d mode=%0d busy=%b want 0 0 1", acc_q.size(), c_mode, busy);
    end
    stall = 0; zero_t = -1; mode_t = -1; grant_t = -1; rsp_at_grant = -1;
    for (int t = 0; t < 40; t++) begin
      step();
      if (zero_t < 0 && outstanding === '0) zero_t = t;
      if (mode_t < 0 && c_mode === 2'd2) mode_t = t;
      if (grant_t < 0 && acc_q.size() > 0) begin grant_t = t; rsp_at_grant = rsp_q.size(); req_vld = '0; end
    end
    n_vec++;
    if (rsp_at_grant != 3) begin n_err++; $display("FAIL ms_drained got %0d rsps at grant want 3", rsp_at_grant); end
    n_vec++;
    if (zero_t < 0 || mode_t - zero_t < 1 || mode_t - zero_t > 2) begin
      n_err++; $display("FAIL ms_mode_time got zero=%0d mode=%0d want mode 1..2 after zero", zero_t, mode_t);
    end
    n_vec++;
    if (acc_q.size() != 1 || acc_q[0] != 1) begin
      n_err++; $display("FAIL ms_first_grant got n=%0d id=%0d want 1 grant to 1", acc_q.size(), acc_q.size() ? acc_q[0] : -1);
    end
    acc_q.delete();
    while (rsp_q.size() > 0) begin
      r = rsp_q.pop_front(); n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL ms_rsp extra id=%0d", r.id); end
      else begin
        e = exp_q.pop_front();
        if (r.id !== e.id || r.data !== e.data) begin
          n_err++; $display("FAIL ms_rsp got id=%0d data=%h want id=%0d data=%h", r.id, r.data, e.id, e.data);
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL ms_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_simultaneous();
    tr_t r, e;
    stall = 1; req_mode = {NR{2'd2}}; req_vld = 4'b0100;
    for (int t = 0; t < 20 && acc_q.size() < 5; t++) step();
    req_vld = '0;
    repeat (3) step();
    n_vec++;
    if (outstanding !== 5'd5) begin n_err++; $display("FAIL sim_setup got cnt=%0d want 5", outstanding); end
    acc_q.delete();
    rel1 = 1;
    step();
    req_vld = 4'b1000;
    step();
    req_vld = '0;
    n_vec++;
    if (acc_q.size() != 1 || acc_q[0] != 3) begin
      n_err++; $display("FAIL sim_accept got n=%0d want one accept from 3", acc_q.size());
    end
    n_vec++;
    if (outstanding !== 5'd5) begin n_err++; $display("FAIL sim_count got %0d want 5", outstanding); end
    step();
    n_vec++;
    if (rsp_q.size() != 1 || rsp_q[0].id != 2) begin
      n_err++; $display("FAIL sim_oldest got n=%0d id=%0d want 1 rsp to 2", rsp_q.size(), rsp_q.size() ? rsp_q[0].id : -1);
    end
    stall = 0;
    repeat (20) step();
    acc_q.delete();
    while (rsp_q.size() > 0) begin
      r = rsp_q.pop_front(); n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL sim_rsp extra id=%0d", r.id); end
      else begin
        e = exp_q.pop_front();
        if (r.id !== e.id || r.data !== e.data) begin
          n_err++; $display("FAIL sim_rsp got id=%0d data=%h want id=%0d data=%h", r.id, r.data, e.id, e.data);
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sim_missing got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_orphan();
    n_vec++;
    if (orphan !== 1'b0 || outstanding !== '0) begin
      n_err++; $display("FAIL orph_pre got orphan=%b cnt=%0d want 0 0", orphan, outstanding);
    end
    inj_d = DW'({$urandom, $urandom}); inj = 1;
    step(); step();
    n_vec++;
    if (orphan !== 1'b1) begin n_err++; $display("FAIL orph_set got %b want 1", orphan); end
    repeat (5) step();
    n_vec++;
    if (orphan !== 1'b1 || outstanding !== '0) begin
      n_err++; $display("FAIL orph_hold got orphan=%b cnt=%0d want 1 0", orphan, outstanding);
    end
    n_vec++;
    if (rsp_q.size() != 0) begin n_err++; $display("FAIL orph_rsp got %0d rsps want 0", rsp_q.size()); rsp_q.delete(); end
  endtask

  task automatic test_reset_midflight();
    stall = 1; req_mode = {NR{2'd2}}; req_vld = 4'b0001;
    for (int t = 0; t < 20 && acc_q.size() < 4; t++) step();
    req_vld = '0;
    step(); step();
    n_vec++;
    if (outstanding !== 5'd4) begin n_err++; $display("FAIL rmf_setup got cnt=%0d want 4", outstanding); end
    rst_n = 1'b0;
    step();
    n_vec++;
    if ({req_rdy, c_vld, rsp_vld, c_data, c_mode, rsp_data, outstanding, busy, orphan} !== '0) begin
      n_err++; $display("FAIL rmf_outputs got cnt=%0d mode=%0d busy=%b orphan=%b cvld=%b want all 0",
                        outstanding, c_mode, busy, orphan, c_vld);
    end
    rst_n = 1'b1;
    exp_q.delete(); acc_q.delete();
    stall = 0;
    repeat (12) step();
    n_vec++;
    if (rsp_q.size() != 0 || orphan !== 1'b1 || outstanding !== '0) begin
      n_err++; $display("FAIL rmf_stray got rsps=%0d orphan=%b cnt=%0d want 0 1 0", rsp_q.size(), orphan, outstanding);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    test_reset();
    test_fairness();
    test_full();
    test_mode_switch();
    test_simultaneous();
    test_orphan();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
